// File: rtl/vx_socket_mem_sched.sv
// Shares one L2 core-side request port among socket requesters using quantum round-robin
// with per-requester read caps. Responses are routed back by the socket index held in the tag LSBs.
module vx_socket_mem_sched #(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 512,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 8,
  parameter int QUANTUM     = 4,
  parameter int SEL_W       = $clog2(NUM_REQS),
  parameter int CNT_W       = $clog2(MAX_PENDING + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              req_valid,
  input  logic [NUM_REQS-1:0]              req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]    req_tag,
  output logic [NUM_REQS-1:0]              req_ready,
  output logic                             mem_req_valid,
  output logic                             mem_req_rw,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_data,
  output logic [TAG_WIDTH+SEL_W-1:0]       mem_req_tag,
  input  logic                             mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
  input  logic [TAG_WIDTH+SEL_W-1:0]       mem_rsp_tag,
  output logic                             mem_rsp_ready,
  output logic [NUM_REQS-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [TAG_WIDTH-1:0]             rsp_tag,
  input  logic [NUM_REQS-1:0]              rsp_ready,
  input  logic                             flush_req,
  output logic                             flush_done,
  output logic                             busy
);

  localparam int QW = $clog2(QUANTUM + 1);
  localparam int MW = TAG_WIDTH + SEL_W;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_pend [NUM_REQS];
  logic [SEL_W-1:0]      r_owner;
  logic [QW-1:0]         r_qcnt;
  logic                  r_out_valid;
  logic                  r_out_rw;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [MW-1:0]         r_out_tag;
  logic                  r_busy;

  logic [NUM_REQS-1:0]   w_elig, w_inc, w_dec;
  logic                  w_keep, w_gnt_valid, w_fire, w_any_pend;
  logic [SEL_W-1:0]      w_gnt, w_idx, w_s;
  logic                  w_s_ok, w_rsp_hs;

  always_comb begin
    w_any_pend = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      w_elig[i]  = req_valid[i] && (r_state == S_RUN) &&
                   (req_rw[i] || (r_pend[i] < CNT_W'(MAX_PENDING)));
      w_any_pend = w_any_pend || (r_pend[i] != '0);
    end
  end

  // Owner keeps the port until its quantum expires; otherwise scan owner+1 .. owner, nearest wins.
  always_comb begin
    w_keep      = w_elig[r_owner] && (r_qcnt < QW'(QUANTUM));
    w_gnt_valid = w_keep;
    w_gnt       = r_owner;
    w_idx       = '0;
    if (!w_keep) begin
      for (int k = NUM_REQS; k >= 1; k--) begin
        w_idx = SEL_W'((int'(r_owner) + k) % NUM_REQS);
        if (w_elig[w_idx]) begin
          w_gnt_valid = 1'b1;
          w_gnt       = w_idx;
        end
      end
    end
  end

  assign w_fire    = reset && w_gnt_valid && (!r_out_valid || mem_req_ready);
  assign req_ready = w_fire ? (NUM_REQS'(1) << w_gnt) : '0;

  assign w_s           = mem_rsp_tag[SEL_W-1:0];
  assign w_s_ok        = int'(w_s) < NUM_REQS;
  assign rsp_valid     = (reset && mem_rsp_valid && w_s_ok) ? (NUM_REQS'(1) << w_s) : '0;
  assign rsp_data      = mem_rsp_data;
  assign rsp_tag       = mem_rsp_tag[MW-1:SEL_W];
  assign mem_rsp_ready = w_s_ok ? rsp_ready[w_s] : 1'b1;
  assign w_rsp_hs      = mem_rsp_valid && mem_rsp_ready;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      w_inc[i] = w_fire && !req_rw[w_gnt] && (w_gnt == SEL_W'(i));
      w_dec[i] = w_rsp_hs && w_s_ok && (w_s == SEL_W'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQS; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_pend[i] <= r_pend[i] + CNT_W'(1);
        else if (!w_inc[i] && w_dec[i] && (r_pend[i] != '0))
          r_pend[i] <= r_pend[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_owner     <= '0;
      r_qcnt      <= '0;
      r_state     <= S_RUN;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= r_out_valid || w_any_pend || (r_state != S_RUN);
      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_owner     <= w_gnt;
        r_qcnt      <= w_keep ? (r_qcnt + QW'(1)) : QW'(1);
      end else if (mem_req_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire) begin
      r_out_rw   <= req_rw[w_gnt];
      r_out_addr <= req_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
      r_out_data <= req_data[w_gnt*DATA_WIDTH +: DATA_WIDTH];
      r_out_tag  <= {req_tag[w_gnt*TAG_WIDTH +: TAG_WIDTH], w_gnt};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (flush_req) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_out_valid && !w_any_pend) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  assign mem_req_valid = r_out_valid;
  assign mem_req_rw    = r_out_rw;
  assign mem_req_addr  = r_out_addr;
  assign mem_req_data  = r_out_data;
  assign mem_req_tag   = r_out_tag;
  assign flush_done    = (r_state == S_DONE);
  assign busy          = r_busy;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      assert (!(|(w_dec & ~w_inc) && (r_pend[w_s] == '0)))
        else $error("pending counter underflow on requester %0d", w_s);
      assert (!(mem_rsp_valid && !w_s_ok))
        else $error("response routed to nonexistent requester %0d", w_s);
    end
  end
`endif

endmodule

// File: tb/tb_vx_socket_mem_sched.sv
// Directed bench for vx_socket_mem_sched: a transaction-level model is checked against the DUT every
// cycle, and each scenario also pins a few hand-derived values.
module tb_vx_socket_mem_sched;
  localparam int NR = 4, AW = 26, DW = 512, TW = 8, MP = 8, Q = 4, SW = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NR-1:0]      req_valid = '0, req_rw = '0, req_ready;
  logic [NR*AW-1:0]   req_addr = '0;
  logic [NR*DW-1:0]   req_data = '0;
  logic [NR*TW-1:0]   req_tag = '0;
  logic               mem_req_valid, mem_req_rw, mem_req_ready = 1'b0;
  logic [AW-1:0]      mem_req_addr;
  logic [DW-1:0]      mem_req_data;
  logic [TW+SW-1:0]   mem_req_tag;
  logic               mem_rsp_valid = 1'b0, mem_rsp_ready;
  logic [DW-1:0]      mem_rsp_data = '0, rsp_data;
  logic [TW+SW-1:0]   mem_rsp_tag = '0;
  logic [NR-1:0]      rsp_valid, rsp_ready = '0;
  logic [TW-1:0]      rsp_tag;
  logic               flush_req = 1'b0, flush_done, busy;

  int n_checks = 0;
  int n_err = 0;

  vx_socket_mem_sched dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
    .req_tag(req_tag), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          m_pend [NR];
  int          m_owner, m_qcnt, m_st;   // m_st: 0 run, 1 drain, 2 done
  bit          m_ov, m_busy, m_rw;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_data;
  logic [TW+SW-1:0] m_tag;

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_pend[i] = 0;
    m_owner = 0; m_qcnt = 0; m_st = 0; m_ov = 0; m_busy = 0;
  endtask

  function automatic bit m_elig(int i);
    return req_valid[i] && (m_st == 0) && (req_rw[i] || (m_pend[i] < MP));
  endfunction

  task automatic m_eval(output int g, output bit fire);
    bit gv = 0;
    g = m_owner;
    if (m_elig(m_owner) && m_qcnt < Q) gv = 1;
    else begin
      for (int k = 1; k <= NR && !gv; k++)
        if (m_elig((m_owner + k) % NR)) begin gv = 1; g = (m_owner + k) % NR; end
    end
    fire = reset && gv && (!m_ov || mem_req_ready);
  endtask

  task automatic m_step();
    int g, s, anyp;
    bit fire, hs;
    m_eval(g, fire);
    s = int'(mem_rsp_tag[SW-1:0]);
    hs = mem_rsp_valid && rsp_ready[s];
    anyp = 0;
    for (int i = 0; i < NR; i++) anyp += m_pend[i];
    m_busy = m_ov || (anyp != 0) || (m_st != 0);
    for (int i = 0; i < NR; i++) begin
      m_pend[i] += ((fire && g == i && !req_rw[g]) ? 1 : 0) - ((hs && s == i) ? 1 : 0);
      if (m_pend[i] < 0) m_pend[i] = 0;
    end
    if (fire) begin
      m_qcnt  = (g == m_owner && m_qcnt < Q) ? m_qcnt + 1 : 1;
      m_owner = g;
      m_ov    = 1;
      m_rw    = req_rw[g];
      m_addr  = req_addr[g*AW +: AW];
      m_data  = req_data[g*DW +: DW];
      m_tag   = {req_tag[g*TW +: TW], SW'(g)};
    end else if (mem_req_ready) m_ov = 0;
    if (m_st == 0 && flush_req) m_st = 1;
    else if (m_st == 1 && !m_ov && anyp == 0) m_st = 2;
    else if (m_st == 2) m_st = 0;
  endtask

  task automatic compare_outputs();
    int g, s;
    bit fire;
    m_eval(g, fire);
    s = int'(mem_rsp_tag[SW-1:0]);
    chk("req_ready", req_ready, fire ? (NR'(1) << g) : NR'(0));
    chk("mem_req_valid", mem_req_valid, m_ov);
    if (m_ov) begin
      chk("mem_req_rw", mem_req_rw, m_rw);
      chk("mem_req_addr", mem_req_addr, m_addr);
      chk("mem_req_data", mem_req_data, m_data);
      chk("mem_req_tag", mem_req_tag, m_tag);
    end
    chk("rsp_valid", rsp_valid, (reset && mem_rsp_valid) ? (NR'(1) << s) : NR'(0));
    chk("mem_rsp_ready", mem_rsp_ready, rsp_ready[s]);
    if (mem_rsp_valid) begin
      chk("rsp_data", rsp_data, mem_rsp_data);
      chk("rsp_tag", rsp_tag, mem_rsp_tag[TW+SW-1:SW]);
    end
    chk("flush_done", flush_done, m_st == 2);
    chk("busy", busy, m_busy);
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk);
      if (!reset) m_reset();
      compare_outputs();
      @(posedge clk);
      if (!reset) m_reset();
      else m_step();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nxt();  @(posedge clk); #1; endtask
  task automatic look(); #3; endtask

  task automatic set_req(input int i, input bit v, input bit rw, input logic [AW-1:0] a,
                         input logic [TW-1:0] t, input logic [31:0] seed);
    req_valid[i] = v; req_rw[i] = rw;
    req_addr[i*AW +: AW] = a;
    req_tag[i*TW +: TW]  = t;
    req_data[i*DW +: DW] = {16{seed}};
  endtask

  task automatic set_rsp(input bit v, input int sock, input logic [TW-1:0] t, input logic [31:0] seed);
    logic [SW-1:0] sel;
    sel = SW'(sock);
    mem_rsp_valid = v;
    mem_rsp_tag   = {t, sel};
    mem_rsp_data  = {16{seed}};
    rsp_ready     = v ? (NR'(1) << sel) : NR'(0);
  endtask

  function automatic int onehot_idx(logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v == (NR'(1) << i)) return i;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int grants [17];
    int exp1 [17];
    int cnt, done_k, ndone;
    bit busy_at [8];
    exp1 = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 0};

    // reset state
    nxt(); look();
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flush_done", flush_done, 1'b0);
    nxt(); nxt();
    reset = 1'b1;
    nxt();

    // 1: continuous writes from all sockets
    mem_req_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      for (int i = 0; i < NR; i++) set_req(i, 1, 1, AW'(i * 256 + c), TW'(8'h10 + i), 32'hA000_0000 + c * 16 + i);
      look();
      grants[c] = onehot_idx(req_ready);
      nxt();
    end
    for (int c = 0; c < 17; c++) chk($sformatf("t1_grant%0d", c), grants[c], exp1[c]);
    req_valid = '0;
    nxt(); nxt();

    // 2: pending cap on socket 2
    set_req(2, 1, 0, 26'h222, 8'h22, 32'h2222_0000);
    cnt = 0;
    for (int c = 0; c < 12; c++) begin look(); if (req_ready[2]) cnt++; nxt(); end
    chk("t2_accepted", cnt, 8);
    set_rsp(1, 2, 8'h22, 32'hD2D2_0001);
    look();
    chk("t2_full_ready", req_ready[2], 1'b0);
    chk("t2_rsp_valid", rsp_valid, 4'b0100);
    nxt();
    set_rsp(0, 0, 8'h00, 32'h0);
    look();
    chk("t2_ninth_fires", req_ready[2], 1'b1);
    nxt();
    req_valid = '0;
    for (int c = 0; c < 8; c++) begin set_rsp(1, 2, 8'h22, 32'hD2D2_0100 + c); nxt(); end
    set_rsp(0, 0, 8'h00, 32'h0);
    nxt();
    chk("t2_model_pend2", m_pend[2], 0);

    // 3: simultaneous read fire and response for socket 1
    set_req(1, 1, 0, 26'h111, 8'h5A, 32'h1111_0000);
    cnt = 0;
    for (int c = 0; c < 3; c++) begin look(); if (req_ready[1]) cnt++; nxt(); end
    chk("t3_pre_reads", cnt, 3);
    set_rsp(1, 1, 8'h5A, 32'hD1D1_0000);
    look();
    chk("t3_req_ready", req_ready, 4'b0010);
    chk("t3_rsp_valid", rsp_valid, 4'b0010);
    chk("t3_rsp_tag", rsp_tag, 8'h5A);
    nxt();
    req_valid = '0;
    set_rsp(0, 0, 8'h00, 32'h0);
    chk("t3_model_pend1", m_pend[1], 3);
    for (int c = 0; c < 3; c++) begin set_rsp(1, 1, 8'h5A, 32'hD1D1_0010 + c); nxt(); end
    set_rsp(0, 0, 8'h00, 32'h0);
    nxt();

    // 4: backpressure
    mem_req_ready = 1'b0;
    set_req(0, 1, 1, 26'h00A, 8'h01, 32'hAAAA_0000);
    look();
    chk("t4_first_accept", req_ready, 4'b0001);
    nxt();
    set_req(0, 1, 1, 26'h00B, 8'h02, 32'hBBBB_0000);
    for (int c = 0; c < 4; c++) begin
      look();
      chk("t4_stall_ready", req_ready, 4'b0000);
      chk("t4_stall_addr", mem_req_addr, 26'h00A);
      nxt();
    end
    mem_req_ready = 1'b1;
    look();
    chk("t4_release_ready", req_ready, 4'b0001);
    chk("t4_release_addr", mem_req_addr, 26'h00A);
    nxt();
    req_valid = '0;
    look();
    chk("t4_next_addr", mem_req_addr, 26'h00B);
    chk("t4_next_tag", mem_req_tag, {8'h02, 2'd0});
    nxt(); nxt();

    // 5: drain with two outstanding reads
    set_req(3, 1, 0, 26'h333, 8'h33, 32'h3333_0000);
    nxt(); nxt();
    req_valid = '0;
    nxt();
    flush_req = 1'b1;
    nxt();
    flush_req = 1'b0;
    set_req(0, 1, 1, 26'h0C0, 8'h0C, 32'hC0C0_0000);
    for (int c = 0; c < 4; c++) begin
      look();
      chk("t5_no_grant", req_ready, 4'b0000);
      chk("t5_busy", busy, 1'b1);
      nxt();
    end
    req_valid = '0;
    set_rsp(1, 3, 8'h33, 32'hD3D3_0000); nxt();
    set_rsp(1, 3, 8'h33, 32'hD3D3_0001); nxt();
    set_rsp(0, 0, 8'h00, 32'h0);
    done_k = -1; ndone = 0;
    for (int k = 1; k <= 6; k++) begin
      look();
      if (flush_done) begin ndone++; if (done_k < 0) done_k = k; end
      busy_at[k] = busy;
      nxt();
    end
    chk("t5_done_cycle", done_k, 2);
    chk("t5_done_pulses", ndone, 1);
    chk("t5_busy_after_done", busy_at[3], 1'b1);
    chk("t5_busy_clear", busy_at[4], 1'b0);

    // 6: reset mid-operation
    set_req(3, 1, 0, 26'h3A0, 8'h3A, 32'h3A3A_0000);
    for (int c = 0; c < 5; c++) nxt();
    mem_req_ready = 1'b0;
    look();
    chk("t6_held_valid", mem_req_valid, 1'b1);
    chk("t6_busy_before", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("t6_rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("t6_rst_req_ready", req_ready, 4'b0000);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_rsp_valid", rsp_valid, 4'b0000);
    nxt(); nxt();
    reset = 1'b1;
    req_valid = '0;
    mem_req_ready = 1'b1;
    nxt();
    look();
    chk("t6_busy_after", busy, 1'b0);
    nxt();
    for (int i = 0; i < NR; i++) set_req(i, 1, 1, AW'(i), TW'(8'h60 + i), 32'h6000_0000 + i);
    look();
    chk("t6_owner0_first", req_ready, 4'b0001);
    nxt();
    req_valid = '0;
    nxt(); nxt();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
